pipelined_barrel_shifter: RTL and testbench

Parametrised, fully pipelined barrel shifter that succeeds the fixed-width shifter in the Barrel_shifter design. It supports four shift modes and a carry-out. A valid/ready handshake with backpressure lets it sit between streaming producers and consumers inside design_1_wrapper. It processes one operation per clock at full throughput, with fixed latency equal to log2(DATA_W) register stages.

---
 rtl/pipelined_barrel_shifter.sv | 160 ++++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with four shift modes, a carry-out and valid/ready flow control.
// There is one register stage per shift-amount bit. Stage k applies a shift of 2^k.
// A stall at the output freezes the whole pipeline. Bubbles are kept, never squeezed out.
module pipelined_barrel_shifter #(
    parameter  int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               sys_clock,
    input  logic               reset_rtl,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_carry
);

    localparam int LAST = SHAMT_W - 1;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    // Shift or rotate one operand by a fixed distance n.
    // In this design n is always 2^k, so it is strictly less than DATA_W.
    // The sign bit stays unchanged through every partial arithmetic shift.
    // That means each SRA stage can take its fill from the current MSB.
    function automatic logic [DATA_W-1:0] shift_stage(
        input logic [DATA_W-1:0] d,
        input logic [1:0]        m,
        input int unsigned       n
    );
        logic [DATA_W-1:0] r;
        case (mode_e'(m))
            MODE_SLL: r = d << n;
            MODE_SRL: r = d >> n;
            MODE_SRA: r = DATA_W'($signed(d) >>> n);
            MODE_ROR: r = (d >> n) | (d << (DATA_W - int'(n)));
            default:  r = d;
        endcase
        return r;
    endfunction

    // Carry-out is the last bit that leaves the operand.
    // Left shifts lose bit DATA_W-s last. Right shifts and rotates lose bit s-1 last.
    // The expression ~s + 1 equals DATA_W - s modulo 2^SHAMT_W, and that value is always in range.
    function automatic logic carry_out(
        input logic [DATA_W-1:0]  d,
        input logic [SHAMT_W-1:0] s,
        input logic [1:0]         m
    );
        logic [SHAMT_W-1:0] idx;
        logic               c;
        idx = {SHAMT_W{1'b0}};
        if (s == {SHAMT_W{1'b0}}) begin
            c = 1'b0;
        end else if (mode_e'(m) == MODE_SLL) begin
            idx = ~s + {{(SHAMT_W-1){1'b0}}, 1'b1};
            c   = d[idx];
        end else begin
            idx = s - {{(SHAMT_W-1){1'b0}}, 1'b1};
            c   = d[idx];
        end
        return c;
    endfunction

    // Pipeline registers. Stage k holds the result of the shift by bit k.
    // Mode and the shift-amount bits that are still unused are kept only for stages that feed a later stage.
    logic [DATA_W-1:0]  r_data  [SHAMT_W];
    logic               r_valid [SHAMT_W];
    logic               r_carry [SHAMT_W];
    logic [1:0]         r_mode  [LAST];
    logic [SHAMT_W-1:0] r_shamt [LAST];

    // Stage inputs and stage shift results
    logic [DATA_W-1:0]  w_in_data  [SHAMT_W];
    logic [1:0]         w_in_mode  [SHAMT_W];
    logic [SHAMT_W-1:0] w_in_shamt [SHAMT_W];
    logic               w_in_valid [SHAMT_W];
    logic               w_in_carry [SHAMT_W];
    logic [DATA_W-1:0]  w_out_data [SHAMT_W];

    logic w_stall;
    logic w_in_ready;

    assign w_stall    = r_valid[LAST] & ~out_ready;
    assign w_in_ready = ~w_stall;

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid[LAST];
    assign out_data  = r_data[LAST];
    assign out_carry = r_carry[LAST];

    // Route each stage's inputs: stage 0 takes the ports, and every later stage takes the previous register
    always_comb begin
        w_in_data[0]  = in_data;
        w_in_mode[0]  = in_mode;
        w_in_shamt[0] = in_shamt;
        w_in_valid[0] = in_valid & w_in_ready;
        w_in_carry[0] = carry_out(in_data, in_shamt, in_mode);
        for (int k = 1; k < SHAMT_W; k++) begin
            w_in_data[k]  = r_data[k-1];
            w_in_mode[k]  = r_mode[k-1];
            w_in_shamt[k] = r_shamt[k-1];
            w_in_valid[k] = r_valid[k-1];
            w_in_carry[k] = r_carry[k-1];
        end
    end

    // Each stage shifts by 2^k when the shift-amount bit now at position 0 is set
    always_comb begin
        for (int k = 0; k < SHAMT_W; k++) begin
            if (w_in_shamt[k][0]) begin
                w_out_data[k] = shift_stage(w_in_data[k], w_in_mode[k], 32'd1 << k);
            end else begin
                w_out_data[k] = w_in_data[k];
            end
        end
    end

    // Advance the whole pipeline one stage unless the output is stalled.
    // Reset clears every stage, so in-flight operations are flushed.
    always_ff @(posedge sys_clock or posedge reset_rtl) begin
        if (reset_rtl) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                r_data[k]  <= {DATA_W{1'b0}};
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
            end
            for (int k = 0; k < LAST; k++) begin
                r_mode[k]  <= 2'b00;
                r_shamt[k] <= {SHAMT_W{1'b0}};
            end
        end else if (!w_stall) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                r_data[k]  <= w_out_data[k];
                r_valid[k] <= w_in_valid[k];
                r_carry[k] <= w_in_carry[k];
            end
            for (int k = 0; k < LAST; k++) begin
                r_mode[k]  <= w_in_mode[k];
                r_shamt[k] <= w_in_shamt[k] >> 1;
            end
        end else begin
            // Output is blocked: every stage holds its value
            for (int k = 0; k < SHAMT_W; k++) begin
                r_data[k]  <= r_data[k];
                r_valid[k] <= r_valid[k];
                r_carry[k] <= r_carry[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized bench for pipelined_barrel_shifter. A bit-level reference
// model plus an ordered queue of expected results with per-item age predicts every output.
module tb_pipelined_barrel_shifter;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          sys_clock = 1'b0;
    logic          reset_rtl = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [SW-1:0] in_shamt  = '0;
    logic [1:0]    in_mode   = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_carry;

    pipelined_barrel_shifter #(.DATA_W(W)) dut (
        .sys_clock (sys_clock),
        .reset_rtl (reset_rtl),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           age;
    } item_t;

    item_t q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    out_count   = 0;
    logic  last_acc    = 1'b0;

    // Reference result: each output bit is picked straight from the operand
    function automatic logic [W-1:0] ref_data(input logic [W-1:0] d, input int s, input logic [1:0] m);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case (m)
                2'b00:   r[i] = (i >= s)    ? d[i-s] : 1'b0;
                2'b01:   r[i] = (i + s < W) ? d[i+s] : 1'b0;
                2'b10:   r[i] = (i + s < W) ? d[i+s] : d[W-1];
                default: r[i] = d[(i+s)%W];
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_carry(input logic [W-1:0] d, input int s, input logic [1:0] m);
        if (s == 0) return 1'b0;
        if (m == 2'b00) return d[W-s];
        return d[s-1];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle, entered at the falling edge with inputs already driven.
    // It compares the outputs with the model, then updates the model across the rising edge.
    task automatic tick();
        logic  exp_valid;
        logic  stall;
        item_t it;
        #1;
        exp_valid = (q.size() > 0) && (q[0].age == SW);
        stall     = exp_valid && !out_ready;
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("in_ready", 64'(in_ready), 64'(!stall));
        if (exp_valid) begin
            check("out_data", 64'(out_data), 64'(q[0].d));
            check("out_carry", 64'(out_carry), 64'(q[0].c));
        end
        last_acc = in_valid && !stall;
        it.d   = ref_data(in_data, int'(in_shamt), in_mode);
        it.c   = ref_carry(in_data, int'(in_shamt), in_mode);
        it.age = 1;
        if (exp_valid && out_ready) begin
            void'(q.pop_front());
            out_count++;
        end
        @(posedge sys_clock);
        if (!stall) begin
            foreach (q[i]) q[i].age++;
        end
        if (last_acc) q.push_back(it);
        @(negedge sys_clock);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                         input logic [1:0] m, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_shamt  = s;
        in_mode   = m;
        out_ready = rdy;
        tick();
    endtask

    // Issue one operation, then check the result against the given constants after exactly SW edges
    task automatic directed(input string tag, input logic [W-1:0] d, input logic [SW-1:0] s,
                            input logic [1:0] m, input logic [W-1:0] ed, input logic ec);
        drive(1'b1, d, s, m, 1'b1);
        repeat (SW - 1) drive(1'b0, W'($urandom), SW'($urandom), 2'($urandom), 1'b1);
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, "_data"}, 64'(out_data), 64'(ed));
        check({tag, "_carry"}, 64'(out_carry), 64'(ec));
        drive(1'b0, '0, '0, 2'b00, 1'b1);
    endtask

    // Send eight SLL operations (value i, shift i), with out_ready low during cycles [s0, s1)
    task automatic run_stream(input string tag, input int s0, input int s1);
        int i;
        int start;
        i     = 0;
        start = out_count;
        for (int cyc = 0; cyc < 30; cyc++) begin
            drive(i < 8, W'(i), SW'(i), 2'b00, !(cyc >= s0 && cyc < s1));
            if (last_acc) i++;
        end
        check({tag, "_accepted"}, 64'(i), 64'(8));
        check({tag, "_delivered"}, 64'(out_count - start), 64'(8));
    endtask

    initial begin
        // Reset values while reset is held
        @(negedge sys_clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_carry", 64'(out_carry), 64'(1'b0));
        reset_rtl = 1'b0;
        @(negedge sys_clock);

        // Directed operations with known results
        directed("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
        directed("sra4",  32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0);
        directed("srl1",  32'hF000_000F, 5'd1,  2'b01, 32'h7800_0007, 1'b1);
        directed("ror8",  32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 1'b0);
        directed("ror0",  32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1'b0);
        directed("sll1c", 32'h4000_0000, 5'd1,  2'b00, 32'h8000_0000, 1'b0);
        directed("sll2c", 32'h4000_0000, 5'd2,  2'b00, 32'h0000_0000, 1'b1);
        directed("sra31", 32'h8000_0001, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0);

        // Back-to-back stream, then the same stream with a 3-cycle output stall
        run_stream("stream", 100, 100);
        run_stream("stall", 6, 9);

        // Asynchronous reset while operations are in flight and one result is at the output
        for (int k = 0; k < 5; k++) drive(1'b1, W'($urandom), SW'(k + 1), 2'b00, 1'b0);
        #2;
        reset_rtl = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(1'b0));
        check("arst_out_data", 64'(out_data), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1'b1));
        q.delete();
        in_valid = 1'b0;
        @(posedge sys_clock);
        @(negedge sys_clock);
        reset_rtl = 1'b0;
        repeat (8) drive(1'b0, W'($urandom), SW'($urandom), 2'($urandom), 1'b1);
        directed("post_rst", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b0);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom), SW'($urandom_range(0, W - 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 7));
        end
        repeat (SW + 3) drive(1'b0, '0, '0, 2'b00, 1'b1);
        check("drain_empty", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
